vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arb_pkg.sv | 21 ++
 rtl/vram_tag_pipe.sv | 35 +++
 rtl/vram_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM read-port arbiter: channel ids, starve-bit
// indices and the tag record carried alongside each in-flight read.
package vram_arb_pkg;

   typedef logic [1:0] chan_id_t;

   localparam chan_id_t VID = 2'd0;
   localparam chan_id_t SPR = 2'd1;
   localparam chan_id_t AUX = 2'd2;

   localparam int unsigned NUM_CH     = 3;
   localparam int unsigned STARVE_VID = 0;
   localparam int unsigned STARVE_SPR = 1;
   localparam int unsigned STARVE_AUX = 2;

   typedef struct packed {
      logic     valid;
      chan_id_t id;
   } tag_t;

endpackage

// File: rtl/vram_tag_pipe.sv
// Fixed-depth shift register that carries {valid, channel id} of each granted
// read so the return can be steered to its requester.
module vram_tag_pipe
   import vram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t [DEPTH-1:0] stage_q;
   tag_t [DEPTH-1:0] stage_d;

   always_comb begin
      stage_d    = stage_q;
      stage_d[0] = tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Three-channel read arbiter for the shared VRAM port: video has absolute
// priority, sprite/aux alternate, returns are steered back via a tag pipeline.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int unsigned AW           = 16,
   parameter int unsigned DW           = 8,
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 64
) (
   input  logic          clk_pixel,
   input  logic          nreset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_gnt,
   output logic          vid_rvalid,
   input  logic          spr_req,
   input  logic [AW-1:0] spr_addr,
   output logic          spr_gnt,
   output logic          spr_rvalid,
   input  logic          aux_req,
   input  logic [AW-1:0] aux_addr,
   output logic          aux_gnt,
   output logic          aux_rvalid,
   output logic [DW-1:0] rdata,
   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_din,
   output logic [2:0]    starve
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   logic [NUM_CH-1:0]          req;
   logic [NUM_CH-1:0]          gnt;
   chan_id_t                   win_id;
   logic [AW-1:0]              win_addr;
   logic                       rr_q, rr_d;
   logic [AW-1:0]              addr_q, addr_d;
   logic [NUM_CH-1:0][CW-1:0]  wcnt_q, wcnt_d;
   logic [NUM_CH-1:0]          starve_q, starve_d;
   tag_t                       tag_in, tag_out;

   assign req = {aux_req, spr_req, vid_req};

   // Grants are gated by nreset so nothing is issued while reset is held.
   always_comb begin
      gnt      = '0;
      win_id   = VID;
      win_addr = vid_addr;
      if (nreset) begin
         if (vid_req) begin
            gnt[VID] = 1'b1;
         end else if (spr_req && (!aux_req || !rr_q)) begin
            gnt[SPR] = 1'b1;
            win_id   = SPR;
            win_addr = spr_addr;
         end else if (aux_req) begin
            gnt[AUX] = 1'b1;
            win_id   = AUX;
            win_addr = aux_addr;
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (gnt[SPR]) begin
         rr_d = 1'b1;
      end else if (gnt[AUX]) begin
         rr_d = 1'b0;
      end
      addr_d   = (|gnt) ? win_addr : addr_q;
      wcnt_d   = '0;
      starve_d = starve_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (req[i] && !gnt[i]) begin
            wcnt_d[i] = (wcnt_q[i] == CW'(STARVE_LIMIT)) ? wcnt_q[i] : wcnt_q[i] + 1'b1;
         end
         if (wcnt_d[i] == CW'(STARVE_LIMIT)) begin
            starve_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_pixel or negedge nreset) begin
      if (!nreset) begin
         rr_q     <= 1'b0;
         addr_q   <= '0;
         wcnt_q   <= '0;
         starve_q <= '0;
      end else begin
         rr_q     <= rr_d;
         addr_q   <= addr_d;
         wcnt_q   <= wcnt_d;
         starve_q <= starve_d;
      end
   end

   assign tag_in = '{valid: |gnt, id: win_id};

   vram_tag_pipe #(
      .DEPTH (MEM_LATENCY)
   ) u_tag_pipe (
      .clk     (clk_pixel),
      .rst_n   (nreset),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign vid_gnt    = gnt[VID];
   assign spr_gnt    = gnt[SPR];
   assign aux_gnt    = gnt[AUX];
   assign mem_en     = |gnt;
   assign mem_addr   = addr_d;
   assign vid_rvalid = tag_out.valid && (tag_out.id == VID);
   assign spr_rvalid = tag_out.valid && (tag_out.id == SPR);
   assign aux_rvalid = tag_out.valid && (tag_out.id == AUX);
   assign rdata      = tag_out.valid ? mem_din : '0;
   assign starve     = starve_q;

endmodule
